// File: rtl/booth_pkg.sv
// Shared widths, state encodings, control-bit indices and the Booth step
// function for the sequential 8x8 signed multiplier.
package booth_pkg;

  localparam int WIDTH = 8;
  localparam int ITERS = 8;
  localparam int CNT_W = $clog2(ITERS);
  localparam int C_W   = 8;

  // Raw encodings kept as plain constants so older blocks can compare
  // against them without pulling in the enum type.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_Q = 3'd1;
  localparam logic [2:0] S_LOAD_Q = 3'd2;
  localparam logic [2:0] S_ITER   = 3'd3;
  localparam logic [2:0] S_OUT_HI = 3'd4;
  localparam logic [2:0] S_OUT_LO = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    WAIT_Q = S_WAIT_Q,
    LOAD_Q = S_LOAD_Q,
    ITER   = S_ITER,
    OUT_HI = S_OUT_HI,
    OUT_LO = S_OUT_LO
  } state_e;

  // Control vector bit positions
  localparam int C_LD_M   = 0;
  localparam int C_LD_Q   = 1;
  localparam int C_ADD    = 2;
  localparam int C_SUB    = 3;
  localparam int C_SHIFT  = 4;
  localparam int C_COUNT  = 5;
  localparam int C_OUT_HI = 6;
  localparam int C_OUT_LO = 7;

  // Working register set {A, Q, Q_1}; A carries one guard bit so that
  // A - M never overflows when M = -128.
  typedef struct packed {
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             q_1;
  } booth_acc_t;

  // One radix-2 Booth iteration: optional add/subtract of the sign-extended
  // multiplicand followed by an arithmetic right shift of {A, Q, Q_1}.
  function automatic booth_acc_t booth_step(input booth_acc_t       cur,
                                            input logic [WIDTH-1:0] m,
                                            input logic             add,
                                            input logic             sub);
    booth_acc_t     nxt;
    logic [WIDTH:0] m9;
    logic [WIDTH:0] sum;
    m9  = {m[WIDTH-1], m};
    sum = cur.a;
    if (add) begin
      sum = cur.a + m9;
    end else if (sub) begin
      sum = cur.a - m9;
    end
    nxt.a   = {sum[WIDTH], sum[WIDTH:1]};
    nxt.q   = {sum[0], cur.q[WIDTH-1:1]};
    nxt.q_1 = cur.q[0];
    return nxt;
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Sequencing FSM for the Booth multiplier. Produces the control vector c
// as a combinational decode of the registered state.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for enable; M captured on the enable edge
//   WAIT_Q | one dead cycle while the bus master switches to Q
//   LOAD_Q | capture Q, clear A / Q_1 / iteration counter
//   ITER   | add/sub + arithmetic shift, eight passes
//   OUT_HI | product high byte on outbus, done high
//   OUT_LO | product low byte on outbus, then back to IDLE
module booth_ctrl
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           q0,
  input  logic           q_1,
  input  logic           last_iter,
  output logic [C_W-1:0] c
);

  state_e state_q;
  state_e state_d;

  // Next-state logic; enable only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = WAIT_Q;
      WAIT_Q:  state_d = LOAD_Q;
      LOAD_Q:  state_d = ITER;
      ITER:    if (last_iter) state_d = OUT_HI;
      OUT_HI:  state_d = OUT_LO;
      OUT_LO:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control decode; forced to zero while reset is held so nothing on the
  // output bus can leak during an asynchronous reset. In IDLE only the
  // start strobe itself raises the M-load bit.
  always_comb begin
    c = '0;
    if (rst_n) begin
      case (state_q)
        IDLE:   c[C_LD_M] = enable;
        LOAD_Q: c[C_LD_Q] = 1'b1;
        ITER: begin
          c[C_ADD]   = ~q0 &  q_1;
          c[C_SUB]   =  q0 & ~q_1;
          c[C_SHIFT] = 1'b1;
          c[C_COUNT] = 1'b1;
        end
        OUT_HI:  c[C_OUT_HI] = 1'b1;
        OUT_LO:  c[C_OUT_LO] = 1'b1;
        default: c = '0;
      endcase
    end
  end

endmodule

// File: rtl/booth_dp.sv
// Booth datapath: operand/accumulator registers, iteration counter and the
// output byte mux, all steered by the control vector c.
module booth_dp
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [C_W-1:0]   c,
  input  logic [WIDTH-1:0] inbus,
  output logic             q0,
  output logic             q_1,
  output logic             last_iter,
  output logic             done,
  output logic [WIDTH-1:0] outbus
);

  logic [WIDTH-1:0] m_q,   m_d;
  logic [WIDTH:0]   a_q,   a_d;
  logic [WIDTH-1:0] q_q,   q_d;
  logic             q_1_q, q_1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  booth_acc_t acc_cur;
  booth_acc_t acc_nxt;

  // Operand load, Booth step and counter update
  always_comb begin
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q_1_d   = q_1_q;
    cnt_d   = cnt_q;
    acc_cur = '{a: a_q, q: q_q, q_1: q_1_q};
    acc_nxt = booth_step(acc_cur, m_q, c[C_ADD], c[C_SUB]);

    if (c[C_LD_M]) begin
      m_d = inbus;
    end

    if (c[C_LD_Q]) begin
      a_d   = '0;
      q_d   = inbus;
      q_1_d = 1'b0;
    end else if (c[C_SHIFT]) begin
      a_d   = acc_nxt.a;
      q_d   = acc_nxt.q;
      q_1_d = acc_nxt.q_1;
    end

    if (c[C_LD_Q]) begin
      cnt_d = '0;
    end else if (c[C_COUNT]) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers; they hold their values between operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      q_1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      a_q   <= a_d;
      q_q   <= q_d;
      q_1_q <= q_1_d;
      cnt_q <= cnt_d;
    end
  end

  // Status back to the FSM and the byte-wide result port
  always_comb begin
    q0        = q_q[0];
    q_1       = q_1_q;
    last_iter = (cnt_q == CNT_W'(ITERS - 1));
    done      = c[C_OUT_HI];
    outbus    = '0;
    if (c[C_OUT_HI]) begin
      outbus = a_q[WIDTH-1:0];
    end else if (c[C_OUT_LO]) begin
      outbus = q_q;
    end
  end

endmodule

// File: rtl/booth.sv
// Sequential 8x8 signed radix-2 Booth multiplier on a shared byte bus.
// M then Q arrive on inbus; the 16-bit product leaves high byte first.
module booth
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] inbus,
  output logic             done,
  output logic [WIDTH-1:0] outbus
);

  logic [C_W-1:0] c;
  logic           q0;
  logic           q_1;
  logic           last_iter;

  booth_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .q0        (q0),
    .q_1       (q_1),
    .last_iter (last_iter),
    .c         (c)
  );

  booth_dp u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c),
    .inbus     (inbus),
    .q0        (q0),
    .q_1       (q_1),
    .last_iter (last_iter),
    .done      (done),
    .outbus    (outbus)
  );

endmodule

// File: tb/tb_booth.sv
// Self-checking bench for the Booth multiplier: directed vector table,
// enable-during-ITER and mid-operation reset sequences, and a random sweep
// against a signed reference product.
module tb_booth;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] inbus;
  logic       done;
  logic [7:0] outbus;

  int n_chk;
  int n_fail;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] m;
    logic [7:0] q;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t vecs[8];

  booth dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .inbus  (inbus),
    .done   (done),
    .outbus (outbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // One full operation. The expected product is pushed when M/Q are driven
  // and popped when done appears. The enable edge is E0; done must first be
  // seen after E10.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] expv, input bit pulse);
    int          k;
    bit          seen;
    logic [15:0] e;
    exp_q.push_back(expv);
    @(negedge clk); enable = 1'b1; inbus = m;
    @(posedge clk);                                   // E0
    @(negedge clk); enable = 1'b0; inbus = 8'($urandom);
    @(posedge clk);                                   // E1, WAIT_Q
    @(negedge clk); inbus = q;
    @(posedge clk);                                   // E2, Q captured
    #1 inbus = 8'($urandom);
    k = 2;
    seen = 1'b0;
    while (k < 30 && !seen) begin
      @(posedge clk);
      k++;
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (k == 6) chk("c_iter_shift_count", 32'(dut.c[5:4]), 32'h3);
        enable = pulse && (k == 5);
        inbus  = 8'($urandom);
      end
    end
    enable = 1'b0;
    e = exp_q.pop_front();
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: done never rose, expected product 0x%04h", e);
      return;
    end
    chk("latency_edges", 32'(k), 32'd10);
    chk("out_hi", 32'(outbus), 32'(e[15:8]));
    chk("c_out_hi", 32'(dut.c), 32'h40);
    @(posedge clk); #1;
    chk("done_width", 32'(done), 32'd0);
    chk("out_lo", 32'(outbus), 32'(e[7:0]));
    chk("c_out_lo", 32'(dut.c), 32'h80);
    @(posedge clk); #1;                               // E12, IDLE
    chk("idle_outbus", 32'(outbus), 32'd0);
    chk("idle_c", 32'(dut.c), 32'd0);
  endtask

  initial begin
    int          quiet;
    logic [7:0]  rm;
    logic [7:0]  rq;
    int          p;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    inbus  = 8'h00;

    vecs[0] = '{m: 8'hFD, q: 8'h05, hi: 8'hFF, lo: 8'hF1};   // -3 * 5 = -15
    vecs[1] = '{m: 8'h80, q: 8'h80, hi: 8'h40, lo: 8'h00};   // -128 * -128
    vecs[2] = '{m: 8'h7F, q: 8'h80, hi: 8'hC0, lo: 8'h80};   // 127 * -128
    vecs[3] = '{m: 8'h00, q: 8'hFF, hi: 8'h00, lo: 8'h00};   // 0 * -1
    vecs[4] = '{m: 8'h06, q: 8'h07, hi: 8'h00, lo: 8'h2A};   // 6 * 7
    vecs[5] = '{m: 8'hFF, q: 8'hFF, hi: 8'h00, lo: 8'h01};   // -1 * -1
    vecs[6] = '{m: 8'h7F, q: 8'h7F, hi: 8'h3F, lo: 8'h01};   // 127 * 127
    vecs[7] = '{m: 8'h80, q: 8'h7F, hi: 8'hC0, lo: 8'h80};   // -128 * 127

    #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_outbus", 32'(outbus), 32'd0);
    chk("reset_c", 32'(dut.c), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].q, {vecs[i].hi, vecs[i].lo}, 1'b0);
    end

    // enable pulsed in the middle of ITER must be ignored
    run_op(8'hFD, 8'h05, 16'hFFF1, 1'b1);
    run_op(8'h7F, 8'h80, 16'hC080, 1'b1);

    // asynchronous reset in the middle of ITER
    @(negedge clk); enable = 1'b1; inbus = 8'h5A;
    @(posedge clk);
    @(negedge clk); enable = 1'b0; inbus = 8'h00;
    @(posedge clk);
    @(negedge clk); inbus = 8'hA5;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_outbus", 32'(outbus), 32'd0);
    chk("midrst_c", 32'(dut.c), 32'd0);
    chk("midrst_state", 32'(dut.u_ctrl.state_q), 32'd0);
    chk("midrst_a", 32'(dut.u_dp.a_q), 32'd0);
    chk("midrst_m", 32'(dut.u_dp.m_q), 32'd0);
    enable = 1'b1;
    #1;
    chk("rst_held_c_with_enable", 32'(dut.c), 32'd0);
    @(negedge clk); enable = 1'b0; rst_n = 1'b1;
    quiet = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done || outbus != 8'h00) quiet++;
    end
    chk("post_reset_no_activity", 32'(quiet), 32'd0);
    run_op(8'h06, 8'h07, 16'h002A, 1'b0);

    // random sweep against the signed reference product
    for (int i = 0; i < 5000; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      p  = int'($signed(rm)) * int'($signed(rq));
      run_op(rm, rq, p[15:0], 1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
